// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   arb_state_e : arbiter state (NORMAL, FORCE_LD)
//   WL_DEF      : default data word length
//   ADDR_W_DEF  : default register address width
package rf_write_arbiter_pkg;

  localparam int WL_DEF     = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    FORCE_LD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Two-entry holding FIFO for load writebacks ({addr, data} words).
//   CLK, RST          : clock, synchronous active-high reset
//   push_i / din_i    : write strobe and word (ignored when full)
//   pop_i             : remove head (ignored when empty)
//   head_o            : current head word
//   empty_o / full_o  : occupancy flags, derived from registered count
module rf_wb_fifo #(
  parameter int W = 37
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the ALU and a buffered load path,
// with a busy scoreboard that produces the decode stall.
//   CLK, RST                          : clock, synchronous active-high reset
//   ALU_Req/ALU_Ready/ALU_Addr/Data   : ALU writeback handshake
//   LD_Req/LD_Ready/LD_Addr/LD_Data   : load writeback into 2-entry FIFO
//   Issue_Valid/Issue_Addr            : marks destination register busy
//   Read_Addr1/2, Stall               : source hazard check
//   RF_Write_Enable_Flag/Address/Data_Address_Input : registered write port
// Optional feature macro RF_WRITE_BYPASS_EN adds Fwd1/2_Valid and Fwd1/2_Data,
// forwarding the in-flight write and masking it from Stall.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int WL         = WL_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ALU_Req,
  output logic              ALU_Ready,
  input  logic [ADDR_W-1:0] ALU_Addr,
  input  logic [WL-1:0]     ALU_Data,
  input  logic              LD_Req,
  output logic              LD_Ready,
  input  logic [ADDR_W-1:0] LD_Addr,
  input  logic [WL-1:0]     LD_Data,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Addr,
  input  logic [ADDR_W-1:0] Read_Addr1,
  input  logic [ADDR_W-1:0] Read_Addr2,
  output logic              Stall,
`ifdef RF_WRITE_BYPASS_EN
  output logic              Fwd1_Valid,
  output logic              Fwd2_Valid,
  output logic [WL-1:0]     Fwd1_Data,
  output logic [WL-1:0]     Fwd2_Data,
`endif
  output logic              RF_Write_Enable_Flag,
  output logic [ADDR_W-1:0] RF_Write_Address,
  output logic [WL-1:0]     RF_Data_Address_Input
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wa_q, wa_d;
  logic [WL-1:0]      wd_q, wd_d;

  logic [ADDR_W+WL-1:0] fifo_head;
  logic                 fifo_empty, fifo_full;
  logic [ADDR_W-1:0]    head_addr;
  logic [WL-1:0]        head_data;
  logic                 alu_win, ld_win, ld_lose;
  logic                 hit1, hit2;

  rf_wb_fifo #(.W(ADDR_W + WL)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (LD_Req),
    .din_i   ({LD_Addr, LD_Data}),
    .pop_i   (ld_win),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_addr = fifo_head[ADDR_W+WL-1:WL];
  assign head_data = fifo_head[WL-1:0];
  assign LD_Ready  = !fifo_full;

  assign ALU_Ready = (state_q == NORMAL);
  assign alu_win   = ALU_Ready && ALU_Req;
  assign ld_win    = !fifo_empty && !alu_win;
  assign ld_lose   = !fifo_empty && alu_win;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d   = '0;
    state_d = NORMAL;
    if (ld_lose) begin
      cnt_d = cnt_inc;
      // The lost cycle that brings the count to the limit schedules the
      // one-cycle forced grant for the following cycle.
      if (cnt_inc == CNT_W'(STARVE_MAX)) state_d = FORCE_LD;
    end
  end

  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (alu_win) begin
      we_d = (ALU_Addr != '0);
      wa_d = ALU_Addr;
      wd_d = ALU_Data;
    end else if (ld_win) begin
      we_d = (head_addr != '0);
      wa_d = head_addr;
      wd_d = head_data;
    end
  end

  // Clear first, then set, so a same-edge issue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[wa_q] = 1'b0;
    if (Issue_Valid && (Issue_Addr != '0)) busy_d[Issue_Addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign RF_Write_Enable_Flag  = we_q;
  assign RF_Write_Address      = wa_q;
  assign RF_Data_Address_Input = wd_q;

  assign hit1 = busy_q[Read_Addr1] && (Read_Addr1 != '0);
  assign hit2 = busy_q[Read_Addr2] && (Read_Addr2 != '0);

`ifdef RF_WRITE_BYPASS_EN
  assign Fwd1_Valid = we_q && (wa_q != '0) && (Read_Addr1 == wa_q);
  assign Fwd2_Valid = we_q && (wa_q != '0) && (Read_Addr2 == wa_q);
  assign Fwd1_Data  = wd_q;
  assign Fwd2_Data  = wd_q;
  assign Stall      = (hit1 && !Fwd1_Valid) || (hit2 && !Fwd2_Valid);
`else
  assign Stall      = hit1 || hit2;
`endif

endmodule
